// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready result port.
// Single-cycle ops produce their result one edge after acceptance. MUL uses a
// shift-add multiplier that takes one multiplier bit per cycle. Each result is
// held stable until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SHIFT = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_ROT   = 3'd7;

  // The final multiply step is taken when the step counter reaches WIDTH-1.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
  } alu_out_t;

  // Single-cycle operations. MUL is handled by the iterative datapath and
  // yields all-zero here.
  function automatic alu_out_t alu_eval(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       opc,
    input logic             right
  );
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] dbl;
    logic [SHW-1:0]     amt;
    alu_out_t           o;
    o    = '0;
    wide = '0;
    dbl  = '0;
    amt  = y[SHW-1:0];
    case (opc)
      OP_ADD: begin
        wide  = {1'b0, x} + {1'b0, y};
        o.res = wide[WIDTH-1:0];
        o.cy  = wide[WIDTH];
        o.ov  = (x[WIDTH-1] == y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b).
        wide  = {1'b0, x} - {1'b0, y};
        o.res = wide[WIDTH-1:0];
        o.cy  = wide[WIDTH];
        o.ov  = (x[WIDTH-1] != y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: o.res = x & y;
      OP_OR:  o.res = x | y;
      OP_XOR: o.res = x ^ y;
      OP_SHIFT: begin
        // An extra guard bit catches the last bit shifted out. It stays 0
        // when the amount is 0.
        if (right) begin
          wide  = {x, 1'b0} >> amt;
          o.res = wide[WIDTH:1];
          o.cy  = wide[0];
        end else begin
          wide  = {1'b0, x} << amt;
          o.res = wide[WIDTH-1:0];
          o.cy  = wide[WIDTH];
        end
      end
      OP_ROT: begin
        // Shifting a doubled copy gives the rotation in one half.
        if (right) begin
          dbl   = {x, x} >> amt;
          o.res = dbl[WIDTH-1:0];
        end else begin
          dbl   = {x, x} << amt;
          o.res = dbl[2*WIDTH-1:WIDTH];
        end
        if (amt == {SHW{1'b0}}) begin
          o.cy = 1'b0;
        end else if (right) begin
          o.cy = o.res[WIDTH-1];
        end else begin
          o.cy = o.res[0];
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  alu_out_t           eval_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_step_s;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               busy_s;
  logic               accept_s;
  logic               mul_last_s;
  state_t             start_state_s;

  assign accept_s      = in_valid && in_ready_s;
  assign mul_last_s    = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
  assign start_state_s = (op == OP_MUL) ? ST_MUL : ST_HOLD;

  // Evaluate the single-cycle operation on the live request inputs.
  always_comb begin
    eval_s = alu_eval(a, b, op, dir);
  end

  // One shift-add step. The upper half accumulates the product and the lower
  // half holds the remaining multiplier bits, LSB first.
  always_comb begin
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step_s = {mul_sum_s, prod_q[WIDTH-1:1]};
  end

  // Handshake and status decode from the current state.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_s = 1'b1;
      ST_MUL:  busy_s     = 1'b1;
      ST_HOLD: begin
        out_valid_s = 1'b1;
        in_ready_s  = out_ready;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // FSM next state. A result retiring in HOLD can overlap the next accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = start_state_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_d = start_state_s;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state. The held result changes only on a single-cycle accept
  // or on the last multiply step.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    if (accept_s && (op == OP_MUL)) begin
      prod_d  = {{WIDTH{1'b0}}, b};
      mcand_d = a;
      cnt_d   = {SHW{1'b0}};
    end else if (accept_s) begin
      result_d = eval_s.res;
      carry_d  = eval_s.cy;
      ovf_d    = eval_s.ov;
      zero_d   = (eval_s.res == {WIDTH{1'b0}});
    end else if (state_q == ST_MUL) begin
      prod_d = prod_step_s;
      cnt_d  = cnt_q + SHW'(1);
      if (mul_last_s) begin
        result_d = prod_step_s[WIDTH-1:0];
        carry_d  = (prod_step_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        ovf_d    = 1'b0;
        zero_d   = (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end else begin
        result_d = result_q;
      end
    end else begin
      prod_d = prod_q;
    end
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      prod_q   <= {(2*WIDTH){1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      cnt_q    <= {SHW{1'b0}};
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8). Vector table, random vectors checked against
// a behavioural model, and directed multi-cycle sequences. Results are scored
// through an expected-result queue.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHIFT = 3'd5, OP_MUL = 3'd6, OP_ROT = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       dir;
    logic [7:0] res;
    logic       c;
    logic       ov;
    logic       z;
  } vec_t;

  logic       clk, rst_n, in_valid, in_ready, dir, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic       zero, carry, overflow, busy;

  int tests = 0;
  int fails = 0;
  vec_t sb[$];
  vec_t mon_e;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .dir(dir), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: integer arithmetic and bit-by-bit shifting.
  function automatic vec_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic d);
    vec_t v;
    int p, sr, amt;
    logic [7:0] r;
    logic c;
    v.op = o; v.a = x; v.b = y; v.dir = d; v.ov = 1'b0;
    r = 8'h00; c = 1'b0;
    amt = int'(y) % 8;
    case (o)
      OP_ADD: begin
        p = int'(x) + int'(y); r = p[7:0]; c = (p > 255);
        sr = int'($signed(x)) + int'($signed(y)); v.ov = (sr > 127) || (sr < -128);
      end
      OP_SUB: begin
        p = int'(x) - int'(y); r = p[7:0]; c = (x < y);
        sr = int'($signed(x)) - int'($signed(y)); v.ov = (sr > 127) || (sr < -128);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHIFT: begin
        r = x;
        for (int i = 0; i < amt; i++) begin
          if (d) begin c = r[0]; r = r >> 1; end
          else begin c = r[7]; r = r << 1; end
        end
      end
      OP_ROT: begin
        r = x;
        for (int i = 0; i < amt; i++) begin
          if (d) begin r = {r[0], r[7:1]}; c = r[7]; end
          else begin r = {r[6:0], r[7]}; c = r[0]; end
        end
      end
      OP_MUL: begin
        p = int'(x) * int'(y); r = p[7:0]; c = (p > 255);
      end
      default: r = 8'h00;
    endcase
    v.res = r; v.c = c; v.z = (r == 8'h00);
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input bit push);
    int guard;
    guard = 0;
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op; dir = v.dir;
    @(negedge clk);
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", guard);
    end else if (push) begin
      sb.push_back(v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every result handed to the consumer is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: actual result %0h with nothing pending, required no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result_op%0d_a%0h_b%0h_d%0d", mon_e.op, mon_e.a, mon_e.b, mon_e.dir),
            {21'd0, result, carry, overflow, zero},
            {21'd0, mon_e.res, mon_e.c, mon_e.ov, mon_e.z});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[23];
  vec_t rv;
  int   nbusy, bad_rdy, stale;

  initial begin
    //          op        a      b      dir   res    c     ov    z
    tbl[0]  = '{OP_ADD,   8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD,   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{OP_ADD,   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{OP_SUB,   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{OP_SUB,   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{OP_SUB,   8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{OP_AND,   8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_OR,    8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_XOR,   8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{OP_SHIFT, 8'h81, 8'h01, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{OP_SHIFT, 8'h81, 8'h01, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{OP_SHIFT, 8'h5A, 8'h08, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{OP_SHIFT, 8'h0F, 8'h04, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{OP_SHIFT, 8'h0F, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{OP_SHIFT, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{OP_ROT,   8'h01, 8'h09, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{OP_ROT,   8'h81, 8'h01, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{OP_ROT,   8'h02, 8'h03, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{OP_ROT,   8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{OP_MUL,   8'd20, 8'd13, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{OP_MUL,   8'd15, 8'd17, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{OP_MUL,   8'd16, 8'd16, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[22] = '{OP_MUL,   8'd0,  8'd77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; op = 3'd0; dir = 1'b0;
    #1;
    chk("rst_outputs", {out_valid, busy, result, zero, carry, overflow}, 13'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", {out_valid, busy, result, zero, carry, overflow}, 13'd0);
    rst_n = 1'b1;

    // The first edge after release accepts; single-cycle ops have latency 1.
    for (int i = 0; i < 23; i++) begin
      send(tbl[i], 1'b1);
      if (tbl[i].op != OP_MUL) chk($sformatf("lat1_vec%0d", i), out_valid, 1'b1);
    end

    for (int i = 0; i < 24; i++) begin
      rv = model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
      send(rv, 1'b1);
    end

    // MUL timing: busy and in_ready low for exactly 8 cycles.
    drain();
    send(model(OP_MUL, 8'd20, 8'd13, 1'b0), 1'b1);
    nbusy = 0; bad_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) nbusy++;
      if (in_ready) bad_rdy++;
    end
    chk("mul_busy_cycles", nbusy, 8);
    chk("mul_in_ready_low", bad_rdy, 0);
    chk("mul_done_valid", {out_valid, busy}, 2'b10);

    // Backpressure, then back-to-back retire and accept.
    drain();
    out_ready = 1'b0;
    send(model(OP_ADD, 8'd200, 8'd100, 1'b0), 1'b1);
    chk("bp_lat1", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", i), {out_valid, in_ready, result, carry, overflow, zero},
          {1'b1, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(model(OP_XOR, 8'h3C, 8'h0F, 1'b0), 1'b1);
    chk("b2b_valid", {out_valid, result}, {1'b1, 8'h33});

    // Reset three cycles into a MUL discards it.
    drain();
    send(model(OP_MUL, 8'd20, 8'd13, 1'b0), 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_mul_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mul_rst_outputs", {out_valid, busy, result, zero, carry, overflow}, 13'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_valid", stale, 0);
    @(posedge clk); #1;
    send(model(OP_ADD, 8'd1, 8'd1, 1'b0), 1'b1);
    chk("post_rst_add", {out_valid, result}, {1'b1, 8'd2});

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
